// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: two-flop input synchroniser, 3-sample mid-bit
// majority vote, false-start rejection, framing-error detection and break recovery.
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int M     = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_SMP0 = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_SMP1 = CNT_W'(M);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t                 state_q;
  logic                   rx_s1_q;
  logic                   rx_s2_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   smp0_q;
  logic                   smp1_q;
  logic                   rx_done_q;
  logic                   frame_err_q;
  logic                   vote_d;
  logic                   at_vote_d;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The third sample is the live synchronised bit, so the vote resolves in the cnt = M+1 cycle.
  assign vote_d    = majority3(smp0_q, smp1_q, rx_s2_q);
  assign at_vote_d = (cnt_q == CNT_VOTE);

  always_ff @(posedge clk) begin
    if (cnt_q == CNT_SMP0) smp0_q <= rx_s2_q;
    if (cnt_q == CNT_SMP1) smp1_q <= rx_s2_q;
    if (state_q == DATA && at_vote_d) shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s2_q) state_q <= START;
        end
        START: begin
          if (at_vote_d && vote_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) state_q <= STOP;
            else                   idx_q   <= idx_q + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop gives half a bit of slack for a fast transmitter.
          if (at_vote_d) begin
            cnt_q <= '0;
            if (vote_d) begin
              rx_data_q <= shift_q;
              rx_done_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RECOVER;
            end
          end
        end
        RECOVER: begin
          cnt_q <= '0;
          if (rx_s2_q) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame-level event model (expected pulses, data and busy
// edges scheduled from the start-bit edge) checked every cycle, plus literal checks.
module tb_uart_rx_os;

  localparam int CPB      = 16;
  localparam int DB       = 8;
  localparam int M        = CPB / 2;
  localparam int DONE_LAT = (DB + 1) * CPB + M + 4;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_BUSY0 = 2;
  localparam int K_BUSY1 = 3;
  localparam int K_RST   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_done;
  logic          frame_err;
  logic          busy;

  uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  int         n_chk = 0;
  int         n_pass = 0;
  bit         chk_en = 1'b0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         last_done_cyc = -1;
  int         last_e0 = 0;
  int         e0 = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_ev(input int c, input int k, input logic [7:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.data = d;
    evq.push_back(e);
  endtask

  // Per-cycle comparison against the scheduled model events.
  always @(negedge clk) begin : cmp
    bit  e_done;
    bit  e_err;
    ev_t e;
    if (chk_en) begin
      e_done = 1'b0;
      e_err  = 1'b0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        e = evq.pop_front();
        if (e.cyc != cyc) check("event_time", 32'(e.cyc), 32'(cyc));
        case (e.kind)
          K_DONE:  begin e_done = 1'b1; exp_data = e.data; end
          K_ERR:   e_err = 1'b1;
          K_BUSY0: check("busy", 32'(busy), 32'd0);
          K_BUSY1: check("busy", 32'(busy), 32'd1);
          K_RST:   exp_data = 8'h00;
          default: ;
        endcase
      end
      check("rx_done", 32'(rx_done), 32'(e_done));
      check("frame_err", 32'(frame_err), 32'(e_err));
      check("rx_data", 32'(rx_data), 32'(exp_data));
      if (rx_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (frame_err) err_cnt++;
    end
  end

  // Hold rx at v for n cycles; entered and left just after a rising edge.
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_v,
                            input int glitch_bit, input bit push);
    int s;
    s = cyc + 1;
    last_e0 = s;
    if (push) begin
      push_ev(s + 1, K_BUSY0, 8'h00);
      push_ev(s + 2, K_BUSY1, 8'h00);
      push_ev(s + DONE_LAT - 1, K_BUSY1, 8'h00);
      if (stop_v) begin
        push_ev(s + DONE_LAT, K_DONE, b);
        push_ev(s + DONE_LAT, K_BUSY0, 8'h00);
      end else begin
        push_ev(s + DONE_LAT, K_ERR, 8'h00);
        push_ev(s + DONE_LAT, K_BUSY1, 8'h00);
      end
    end
    drive(1'b0, CPB);
    for (int i = 0; i < DB; i++) begin
      if (i == glitch_bit) begin
        drive(b[i], M + 1);
        drive(~b[i], 1);
        drive(b[i], CPB - M - 2);
      end else begin
        drive(b[i], CPB);
      end
    end
    drive(stop_v, stop_len);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_done", 32'(rx_done), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    drive(1'b1, 5);

    // Single good frame
    send_frame(8'hA5, CPB, 1'b1, -1, 1'b1);
    drive(1'b1, 10);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_done_count", 32'(done_cnt), 32'd1);
    check("a5_done_time", 32'(last_done_cyc - last_e0), 32'd156);
    check("a5_no_err", 32'(err_cnt), 32'd0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, CPB, 1'b1, -1, 1'b1);
    send_frame(8'hFF, CPB, 1'b1, -1, 1'b1);
    drive(1'b1, 10);
    check("b2b_done_count", 32'(done_cnt), 32'd3);
    check("b2b_data", 32'(rx_data), 32'hFF);

    // False start: 4-cycle low pulse, rejected at the START vote
    e0 = cyc + 1;
    push_ev(e0 + 1, K_BUSY0, 8'h00);
    push_ev(e0 + 2, K_BUSY1, 8'h00);
    push_ev(e0 + M + 3, K_BUSY1, 8'h00);
    push_ev(e0 + M + 4, K_BUSY0, 8'h00);
    drive(1'b0, 4);
    drive(1'b1, 30);
    check("fs_done_count", 32'(done_cnt), 32'd3);
    check("fs_err_count", 32'(err_cnt), 32'd0);
    check("fs_busy", 32'(busy), 32'd0);

    // Stop bit held low for three bit times, then recovery and a good frame
    send_frame(8'h3C, 3 * CPB, 1'b0, -1, 1'b1);
    check("brk_busy_recover", 32'(busy), 32'd1);
    check("brk_err_count", 32'(err_cnt), 32'd1);
    check("brk_data_kept", 32'(rx_data), 32'hFF);
    drive(1'b1, 10);
    check("brk_busy_idle", 32'(busy), 32'd0);
    send_frame(8'h5A, CPB, 1'b1, -1, 1'b1);
    drive(1'b1, 10);
    check("after_brk_data", 32'(rx_data), 32'h5A);
    check("after_brk_done_count", 32'(done_cnt), 32'd4);

    // One-cycle inverted glitch at mid-bit of data bit 3
    send_frame(8'h81, CPB, 1'b1, 3, 1'b1);
    drive(1'b1, 10);
    check("glitch_data", 32'(rx_data), 32'h81);
    check("glitch_done_count", 32'(done_cnt), 32'd5);

    // Reset pulse in the middle of data bit 4 of an aborted 0xF0 frame
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b0, CPB);
    drive(1'b1, M);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_ev(cyc, K_RST, 8'h00);
    rst = 1'b0;
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    drive(1'b1, 5 * CPB);
    check("rst_no_pulse", 32'(done_cnt), 32'd5);
    send_frame(8'h42, CPB, 1'b1, -1, 1'b1);
    drive(1'b1, 10);
    check("post_rst_data", 32'(rx_data), 32'h42);
    check("post_rst_done_count", 32'(done_cnt), 32'd6);
    check("total_err_count", 32'(err_cnt), 32'd1);
    check("events_drained", 32'(evq.size()), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver that recovers 8N1 frames from the serial line driven by the `uart` transmitter. It synchronises the asynchronous `rx` input and takes a 3-sample majority vote at mid-bit. It rejects false starts, flags framing errors, and presents each received byte with a one-cycle strobe. It is the standalone receive end for loopback and board-level links, clocked by the 100 MHz system clock.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: serial line; idles high; asynchronous to `clk`.
- `rx_data` output DATA_BITS: last correctly framed byte; held until the next good frame.
- `rx_done` output 1: one-cycle pulse when `rx_data` updates.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Synchroniser: two flops, `rx_s1` then `rx_s2`, both reset to 1. The FSM uses only `rx_s2`.
- Bit counter `cnt`, 0..CLKS_PER_BIT-1, cleared on every state entry. Let M = CLKS_PER_BIT/2.
- Majority vote: take samples at cnt = M-1, M and M+1. The voted bit (≥ 2 ones gives 1) is valid in the cycle where cnt = M+1.
- IDLE: when `rx_s2` = 0, go to START.
- START:
  - At the vote, a result of 1 is a false start: go to IDLE with no pulse.
  - Otherwise, at cnt = CLKS_PER_BIT-1, go to DATA.
- DATA:
  - At each vote, shift the voted bit into the shift register MSB, shifting right, so the LSB arrives first.
  - At cnt = CLKS_PER_BIT-1, advance the bit index.
  - After DATA_BITS bits, go to STOP.
- STOP, at the vote:
  - Voted 1: load `rx_data` from the shift register, pulse `rx_done`, go to IDLE directly. This leaves slack for back-to-back frames from a slightly fast transmitter.
  - Voted 0: pulse `frame_err`, leave `rx_data` unchanged, go to RECOVER.
- RECOVER: wait until `rx_s2` = 1, then go to IDLE. A held-low line (break) never creates a new frame.
- `rx_done` and `frame_err` are never high in the same cycle. Neither can repeat in consecutive cycles.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, sync flops 1.
  - `rx_data` 0x00.
  - `rx_done`, `frame_err` and `busy` all 0.
- `rst` mid-frame: discard the frame and return to IDLE on the next edge with no pulse. A low `rx` after reset release starts a new frame through the synchroniser.
- Let E0 be the edge at which `rx_s1` first captures 0:
  - START is entered at E0+2.
  - DATA is entered at E0+2+CLKS_PER_BIT.
  - STOP is entered at E0+2+(DATA_BITS+1)·CLKS_PER_BIT.
  - `rx_done` is high during the cycle after edge E0+(DATA_BITS+1)·CLKS_PER_BIT+M+4. With default parameters this is E0+156.
- `busy` rises in the cycle after E0+2. It falls in the same cycle as `rx_done` (good frame) or in the cycle after the return to IDLE.
- Input glitches of one clock or less at a sample point are rejected by the vote. Glitches in IDLE shorter than 2 cycles can still trigger START; they are then rejected as a false start.

## Test plan
- Reset, then drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1 LSB first, stop) with 16 clocks per bit. Required: `rx_data` = 0xA5 and `rx_done` pulses exactly once, at E0+156. `frame_err` stays 0 throughout.
- Back-to-back 0x00 then 0xFF with no idle gap, second start bit immediately after the first stop bit. Required: two `rx_done` pulses, carrying 0x00 then 0xFF.
- Low pulse of 4 cycles on an idle line. Required: `busy` rises, then returns to 0 after the START vote. No `rx_done` or `frame_err`.
- Frame 0x3C with the stop bit held low for 3 bit times. Required:
  - `frame_err` pulses once.
  - `rx_data` keeps the previous value (0xFF).
  - The FSM stays in RECOVER until `rx` rises, then receives a following 0x5A correctly.
- Frame 0x81 with a single-cycle inverted glitch at cnt = M of bit 3. Required: `rx_data` = 0x81.
- Assert `rst` for 1 cycle during data bit 4 of a frame. Required: all outputs return to reset values and no pulse occurs. The next full frame 0x42 is received correctly.
